// File: rtl/cdb_rr_arbiter_if.sv
// Bundle between functional-unit output stages and the common data bus.
//   fu_valid / fu_result      : per-FU completed result (FU side drives)
//   fu_ready                  : per-FU same-cycle grant (arbiter drives)
//   cdb_valid/cdb_rs_id/cdb_result : per-lane registered broadcast
//   retiring_stations         : mask of FUs broadcast this cycle
// master = functional-unit / producer side, slave = arbiter side.
interface cdb_rr_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned FU_COUNT   = 5,
   parameter int unsigned CDB_PORTS  = 2,
   parameter int unsigned TAG_WIDTH  = $clog2(FU_COUNT)
);
   logic [FU_COUNT-1:0]   fu_valid;
   logic [DATA_WIDTH-1:0] fu_result [FU_COUNT];
   logic [FU_COUNT-1:0]   fu_ready;
   logic [CDB_PORTS-1:0]  cdb_valid;
   logic [TAG_WIDTH-1:0]  cdb_rs_id [CDB_PORTS];
   logic [DATA_WIDTH-1:0] cdb_result [CDB_PORTS];
   logic [FU_COUNT-1:0]   retiring_stations;

   modport master (
      output fu_valid, fu_result,
      input  fu_ready, cdb_valid, cdb_rs_id, cdb_result, retiring_stations
   );

   modport slave (
      input  fu_valid, fu_result,
      output fu_ready, cdb_valid, cdb_rs_id, cdb_result, retiring_stations
   );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// Round-robin multi-lane common-data-bus arbiter.
// Each cycle grants up to CDB_PORTS valid FUs, scanning from rr_ptr with
// modulo-FU_COUNT wrap; the n-th grant in scan order lands on lane n one
// cycle later. fu_ready is the combinational grant (0 under rst or flush).
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous squash of grants and next-cycle broadcast
//   bus   : cdb_rr_arbiter_if.slave (FU requests in, grants and CDB out)
module cdb_rr_arbiter #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned FU_COUNT   = 5,
   parameter int unsigned CDB_PORTS  = 2,
   parameter int unsigned TAG_WIDTH  = $clog2(FU_COUNT)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   cdb_rr_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(CDB_PORTS + 1);

   logic [TAG_WIDTH-1:0]  rr_ptr;
   logic [TAG_WIDTH-1:0]  next_ptr;
   logic [TAG_WIDTH-1:0]  last_idx;
   logic [TAG_WIDTH-1:0]  idx;
   logic [FU_COUNT-1:0]   grant;
   logic [CNT_W-1:0]      g_cnt;
   logic [CDB_PORTS-1:0]  lane_vld;
   logic [TAG_WIDTH-1:0]  lane_id  [CDB_PORTS];
   logic [DATA_WIDTH-1:0] lane_res [CDB_PORTS];
   int unsigned           pos;

   // Grant selection: rotate from rr_ptr, take the first CDB_PORTS requesters.
   always_comb begin
      grant    = '0;
      g_cnt    = '0;
      lane_vld = '0;
      last_idx = rr_ptr;
      idx      = '0;
      pos      = 0;
      for (int unsigned k = 0; k < CDB_PORTS; k++) begin
         lane_id[k] = '0;
      end
      for (int unsigned j = 0; j < FU_COUNT; j++) begin
         // rr_ptr + j < 2*FU_COUNT, so one subtract keeps the index in range.
         pos = 32'(rr_ptr) + j;
         if (pos >= FU_COUNT) begin
            pos = pos - FU_COUNT;
         end
         idx = TAG_WIDTH'(pos);
         if (bus.fu_valid[idx] && (32'(g_cnt) < CDB_PORTS)) begin
            grant[idx] = 1'b1;
            for (int unsigned k = 0; k < CDB_PORTS; k++) begin
               if (32'(g_cnt) == k) begin
                  lane_vld[k] = 1'b1;
                  lane_id[k]  = idx;
               end
            end
            g_cnt    = CNT_W'(g_cnt + 1'b1);
            last_idx = idx;
         end
      end
   end

   // Pointer moves just past the last granted FU, wrapping at FU_COUNT.
   always_comb begin
      next_ptr = '0;
      if (last_idx != TAG_WIDTH'(FU_COUNT - 1)) begin
         next_ptr = TAG_WIDTH'(last_idx + 1'b1);
      end
   end

   // Lane payload mux; unused lanes carry zero rather than stale data.
   always_comb begin
      for (int unsigned k = 0; k < CDB_PORTS; k++) begin
         lane_res[k] = '0;
         if (lane_vld[k]) begin
            lane_res[k] = bus.fu_result[lane_id[k]];
         end
      end
   end

   assign bus.fu_ready = (rst || flush) ? '0 : grant;

   // Broadcast registers and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr                <= '0;
         bus.cdb_valid         <= '0;
         bus.retiring_stations <= '0;
         for (int unsigned k = 0; k < CDB_PORTS; k++) begin
            bus.cdb_rs_id[k]  <= '0;
            bus.cdb_result[k] <= '0;
         end
      end else if (flush) begin
         bus.cdb_valid         <= '0;
         bus.retiring_stations <= '0;
         for (int unsigned k = 0; k < CDB_PORTS; k++) begin
            bus.cdb_rs_id[k]  <= '0;
            bus.cdb_result[k] <= '0;
         end
      end else begin
         bus.cdb_valid         <= lane_vld;
         bus.retiring_stations <= grant;
         for (int unsigned k = 0; k < CDB_PORTS; k++) begin
            bus.cdb_rs_id[k]  <= lane_id[k];
            bus.cdb_result[k] <= lane_res[k];
         end
         if (g_cnt != '0) begin
            rr_ptr <= next_ptr;
         end
      end
   end
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed and randomised bench for cdb_rr_arbiter (FU_COUNT=5, CDB_PORTS=2).
module tb_cdb_rr_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   cdb_rr_arbiter_if #(.DATA_WIDTH(64), .FU_COUNT(5), .CDB_PORTS(2)) bus ();

   cdb_rr_arbiter #(.DATA_WIDTH(64), .FU_COUNT(5), .CDB_PORTS(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_results(input logic [63:0] base);
      for (int i = 0; i < 5; i++) bus.fu_result[i] = base + 64'(i);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush = 1'b0;
      bus.fu_valid = 5'b00000;
      set_results(64'h0);
      #3;
      n_tests++;
      if ({bus.cdb_valid, bus.retiring_stations, bus.cdb_rs_id[0], bus.cdb_rs_id[1]} !== 13'd0 ||
          bus.cdb_result[0] !== 64'd0 || bus.cdb_result[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b ret=%b expected all zero", bus.cdb_valid, bus.retiring_stations);
      end
      bus.fu_valid = 5'b11111;
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 00000", bus.fu_ready);
      end
      bus.fu_valid = 5'b00000;
      tick();
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (dut.rr_ptr !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr);
      end
   endtask

   task automatic test_all_valid();
      logic [2:0] l0_tab [4];
      logic [2:0] l1_tab [4];
      logic [4:0] rdy_tab [5];
      l0_tab  = '{3'd0, 3'd2, 3'd4, 3'd1};
      l1_tab  = '{3'd1, 3'd3, 3'd0, 3'd2};
      rdy_tab = '{5'b00011, 5'b01100, 5'b10001, 5'b00110, 5'b11000};
      set_results(64'h100);
      bus.fu_valid = 5'b11111;
      #1;
      n_tests++;
      if (bus.fu_ready !== rdy_tab[0]) begin
         n_fail++;
         $display("FAIL allvalid_ready0: got %b expected %b", bus.fu_ready, rdy_tab[0]);
      end
      for (int s = 0; s < 4; s++) begin
         tick();
         n_tests++;
         if ({bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.retiring_stations} !==
             {2'b11, l0_tab[s], l1_tab[s], rdy_tab[s]} ||
             bus.cdb_result[0] !== 64'h100 + 64'(l0_tab[s]) ||
             bus.cdb_result[1] !== 64'h100 + 64'(l1_tab[s])) begin
            n_fail++;
            $display("FAIL allvalid_lanes step %0d: got ids %0d,%0d valid=%b ret=%b expected ids %0d,%0d ret=%b",
                     s, bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.cdb_valid, bus.retiring_stations,
                     l0_tab[s], l1_tab[s], rdy_tab[s]);
         end
         n_tests++;
         if (bus.fu_ready !== rdy_tab[s+1]) begin
            n_fail++;
            $display("FAIL allvalid_ready step %0d: got %b expected %b", s, bus.fu_ready, rdy_tab[s+1]);
         end
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({bus.cdb_valid, bus.retiring_stations, bus.fu_ready, bus.cdb_rs_id[0], bus.cdb_rs_id[1]} !== 18'd0 ||
          bus.cdb_result[0] !== 64'd0 || bus.cdb_result[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b ret=%b ready=%b expected all zero",
                  bus.cdb_valid, bus.retiring_stations, bus.fu_ready);
      end
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b00011) begin
         n_fail++;
         $display("FAIL async_reset_restart: got %b expected 00011", bus.fu_ready);
      end
      bus.fu_valid = 5'b00000;
      tick();
   endtask

   task automatic test_single();
      bus.fu_valid = 5'b01000;
      bus.fu_result[3] = 64'hDEAD;
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b01000) begin
         n_fail++;
         $display("FAIL single_ready: got %b expected 01000", bus.fu_ready);
      end
      tick();
      bus.fu_valid = 5'b00000;
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.retiring_stations} !==
          {2'b01, 3'd3, 3'd0, 5'b01000} ||
          bus.cdb_result[0] !== 64'hDEAD || bus.cdb_result[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL single_lanes: got valid=%b id0=%0d res0=%h id1=%0d res1=%h ret=%b expected 01/3/dead/0/0/01000",
                  bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_result[0], bus.cdb_rs_id[1], bus.cdb_result[1],
                  bus.retiring_stations);
      end
      n_tests++;
      if (dut.rr_ptr !== 3'd4) begin
         n_fail++;
         $display("FAIL single_ptr: got %0d expected 4", dut.rr_ptr);
      end
   endtask

   task automatic test_wrap();
      bus.fu_valid = 5'b10001;
      bus.fu_result[4] = 64'hAAAA;
      bus.fu_result[0] = 64'hBBBB;
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b10001) begin
         n_fail++;
         $display("FAIL wrap_ready: got %b expected 10001", bus.fu_ready);
      end
      tick();
      bus.fu_valid = 5'b00000;
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1], dut.rr_ptr} !== {2'b11, 3'd4, 3'd0, 3'd1} ||
          bus.cdb_result[0] !== 64'hAAAA || bus.cdb_result[1] !== 64'hBBBB) begin
         n_fail++;
         $display("FAIL wrap_lanes: got ids %0d,%0d valid=%b ptr=%0d expected ids 4,0 valid=11 ptr=1",
                  bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.cdb_valid, dut.rr_ptr);
      end
      tick();
      n_tests++;
      if ({bus.cdb_valid, bus.retiring_stations, bus.cdb_rs_id[0], bus.cdb_rs_id[1], dut.rr_ptr} !==
          {2'b00, 5'b00000, 3'd0, 3'd0, 3'd1} ||
          bus.cdb_result[0] !== 64'd0 || bus.cdb_result[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL idle_zeroed: got valid=%b ret=%b res0=%h ptr=%0d expected all zero, ptr=1",
                  bus.cdb_valid, bus.retiring_stations, bus.cdb_result[0], dut.rr_ptr);
      end
   endtask

   task automatic test_flush();
      set_results(64'h200);
      bus.fu_valid = 5'b11111;
      flush = 1'b1;
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b00000) begin
         n_fail++;
         $display("FAIL flush_ready: got %b expected 00000", bus.fu_ready);
      end
      tick();
      flush = 1'b0;
      n_tests++;
      if ({bus.cdb_valid, bus.retiring_stations, bus.cdb_rs_id[0], bus.cdb_rs_id[1], dut.rr_ptr} !==
          {2'b00, 5'b00000, 3'd0, 3'd0, 3'd1} ||
          bus.cdb_result[0] !== 64'd0 || bus.cdb_result[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL flush_lanes: got valid=%b ret=%b ptr=%0d expected zero lanes, ptr=1",
                  bus.cdb_valid, bus.retiring_stations, dut.rr_ptr);
      end
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b00110) begin
         n_fail++;
         $display("FAIL flush_resume_ready: got %b expected 00110", bus.fu_ready);
      end
      tick();
      bus.fu_valid = 5'b11001;
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1]} !== {2'b11, 3'd1, 3'd2} ||
          bus.cdb_result[0] !== 64'h201 || bus.cdb_result[1] !== 64'h202) begin
         n_fail++;
         $display("FAIL flush_drain1: got ids %0d,%0d valid=%b expected 1,2 valid=11",
                  bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.cdb_valid);
      end
      #1;
      n_tests++;
      if (bus.fu_ready !== 5'b11000) begin
         n_fail++;
         $display("FAIL flush_drain_ready: got %b expected 11000", bus.fu_ready);
      end
      tick();
      bus.fu_valid = 5'b00001;
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1]} !== {2'b11, 3'd3, 3'd4} ||
          bus.cdb_result[0] !== 64'h203 || bus.cdb_result[1] !== 64'h204) begin
         n_fail++;
         $display("FAIL flush_drain2: got ids %0d,%0d valid=%b expected 3,4 valid=11",
                  bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.cdb_valid);
      end
      tick();
      bus.fu_valid = 5'b00000;
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.retiring_stations} !==
          {2'b01, 3'd0, 3'd0, 5'b00001} ||
          bus.cdb_result[0] !== 64'h200 || bus.cdb_result[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL flush_drain3: got valid=%b id0=%0d res0=%h ret=%b expected 01/0/200/00001",
                  bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_result[0], bus.retiring_stations);
      end
      tick();
   endtask

   task automatic test_random();
      logic [4:0]  pend;
      logic [4:0]  exp_mask;
      logic [4:0]  seen;
      logic [4:0]  rdy;
      logic [2:0]  id;
      logic [63:0] val [5];
      logic [63:0] exp_res [5];
      int          wait_c [5];
      int          want;
      bit          ok;
      pend = '0;
      exp_mask = '0;
      for (int i = 0; i < 5; i++) begin
         val[i] = '0;
         exp_res[i] = '0;
         wait_c[i] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         ok = 1'b1;
         seen = '0;
         if (bus.retiring_stations !== exp_mask) ok = 1'b0;
         if ($countones(bus.cdb_valid) != $countones(exp_mask)) ok = 1'b0;
         if (bus.cdb_valid[1] && !bus.cdb_valid[0]) ok = 1'b0;
         for (int k = 0; k < 2; k++) begin
            if (bus.cdb_valid[k]) begin
               id = bus.cdb_rs_id[k];
               if (id > 3'd4) ok = 1'b0;
               else if (!exp_mask[id] || seen[id] || bus.cdb_result[k] !== exp_res[id]) ok = 1'b0;
               else seen[id] = 1'b1;
            end else if (bus.cdb_rs_id[k] !== 3'd0 || bus.cdb_result[k] !== 64'd0) begin
               ok = 1'b0;
            end
         end
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL rnd_cdb cycle %0d: got valid=%b ids=%0d,%0d ret=%b expected mask=%b",
                     c, bus.cdb_valid, bus.cdb_rs_id[0], bus.cdb_rs_id[1], bus.retiring_stations, exp_mask);
         end
         for (int i = 0; i < 5; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               val[i] = {$urandom, $urandom};
               wait_c[i] = 0;
            end
            bus.fu_result[i] = val[i];
         end
         bus.fu_valid = pend;
         #1;
         rdy = bus.fu_ready;
         want = ($countones(pend) < 2) ? $countones(pend) : 2;
         n_tests++;
         if ((rdy & ~pend) != 5'b00000 || $countones(rdy) != want) begin
            n_fail++;
            $display("FAIL rnd_grant cycle %0d: got ready=%b with valid=%b expected %0d grants within valid",
                     c, rdy, pend, want);
         end
         exp_mask = rdy;
         ok = 1'b1;
         for (int i = 0; i < 5; i++) begin
            if (rdy[i]) begin
               exp_res[i] = val[i];
               pend[i] = 1'b0;
            end else if (pend[i]) begin
               wait_c[i]++;
               if (wait_c[i] >= 3) ok = 1'b0;
            end
         end
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL rnd_fairness cycle %0d: got waits %0d %0d %0d %0d %0d expected each below 3",
                     c, wait_c[0], wait_c[1], wait_c[2], wait_c[3], wait_c[4]);
         end
         tick();
      end
      bus.fu_valid = 5'b00000;
      tick();
   endtask

   initial begin
      test_reset();
      test_all_valid();
      test_async_reset();
      test_single();
      test_wrap();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cdb_rr_arbiter.md
# cdb_rr_arbiter

Registered, multi-lane common-data-bus arbiter. Each cycle it collects completed results from up to `FU_COUNT` functional units and grants up to `CDB_PORTS` of them in round-robin order. Granted results are broadcast on the CDB lanes one cycle later. It sits between the functional-unit output stages and the reservation stations / register-file tag compare. It replaces fixed-priority single-lane arbitration with fair, backpressured, multi-lane broadcast.

## Interface
- `DATA_WIDTH`, 64, result width.
- `FU_COUNT`, 5, number of functional units / reservation-station IDs; must be ≥ 2.
- `CDB_PORTS`, 2, broadcast lanes per cycle; must satisfy 1 ≤ `CDB_PORTS` ≤ `FU_COUNT`.
- `TAG_WIDTH`, `$clog2(FU_COUNT)`, width of the station ID.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous squash of grants and outputs.
- `fu_valid[FU_COUNT]` in 1 each: FU i holds a completed result.
- `fu_result[FU_COUNT]` in `DATA_WIDTH` each: result of FU i; stable while `fu_valid[i]` is high and not yet granted.
- `fu_ready[FU_COUNT]` out 1 each: combinational grant; FU i's result is accepted this cycle.
- `cdb_valid[CDB_PORTS]` out 1 each: lane k carries a result this cycle.
- `cdb_rs_id[CDB_PORTS]` out `TAG_WIDTH` each: station ID on lane k.
- `cdb_result[CDB_PORTS]` out `DATA_WIDTH` each: result on lane k.
- `retiring_stations` out `FU_COUNT`: bit i is set iff FU i is on some lane this cycle.

## Operation
- Internal state:
  - `rr_ptr` (`TAG_WIDTH` bits, range 0..`FU_COUNT`-1): highest-priority FU for the current cycle.
  - Output registers for all lanes.
- Grant selection (combinational, each cycle):
  - Scan FU indices `rr_ptr`, `rr_ptr`+1, …, wrapping modulo `FU_COUNT`.
  - The first `CDB_PORTS` indices with `fu_valid` set are granted.
  - The n-th granted FU in scan order maps to lane n.
  - `fu_ready[i]`=1 iff FU i is granted and `flush`=0.
- Handshake:
  - A transfer occurs when `fu_valid[i]` && `fu_ready[i]`.
  - An FU keeps `fu_valid` asserted with a stable result until `fu_ready` is seen.
  - `fu_ready` never asserts for an FU whose `fu_valid`=0.
- Output register update (rising edge):
  - Lanes 0..g-1 load `{1, id, result}` of the granted FUs, where g = number granted.
  - Lanes g..`CDB_PORTS`-1 load `{0, 0, 0}`; unused lanes are always zeroed, never stale.
  - `retiring_stations` loads the grant mask.
- Pointer update:
  - If g>0: `rr_ptr` ← (index of the last granted FU + 1) mod `FU_COUNT`.
  - If g=0: `rr_ptr` is unchanged.
- Flush:
  - No grants that cycle.
  - Next cycle all lanes are invalid, zeroed, and `retiring_stations`=0.
  - `rr_ptr` is unchanged.
- Reset (async):
  - All `cdb_*` outputs and `retiring_stations` become 0 immediately.
  - `rr_ptr` becomes 0.
  - `fu_ready` is forced to 0 while `rst` is high.
- Wrap-around is modulo `FU_COUNT`; it must be correct for non-power-of-two `FU_COUNT`, with no out-of-range pointer values.
- Simultaneous `flush` and `rst`: reset dominates.

## Timing
- Grant latency: 0 cycles (`fu_ready` is combinational from `fu_valid`, `rr_ptr`, `flush`, `rst`).
- Broadcast latency: 1 cycle (the cycle after the handshake, result is on the CDB).
- Throughput: up to `CDB_PORTS` results per cycle, sustained.
- Fairness: any FU holding `fu_valid` is granted within ⌈`FU_COUNT`/`CDB_PORTS`⌉ cycles of asserting it, absent `flush` and `rst`.
- No combinational path from `fu_result` to any output.
- Reset values:
  - `cdb_valid`=0, `cdb_rs_id`=0, `cdb_result`=0.
  - `retiring_stations`=0.
  - `fu_ready`=0.

## Test plan
All scenarios use `FU_COUNT`=5 and `CDB_PORTS`=2.
- Reset:
  - Stimulus: assert `rst` asynchronously mid-cycle while lanes are valid.
  - Required response: all `cdb_valid`=0, `retiring_stations`=5'b00000 with no clock edge; after release, first grant starts from FU 0.
- Single requester:
  - Stimulus: only `fu_valid[3]`=1, `fu_result[3]`=64'hDEAD.
  - Required response: `fu_ready`=5'b01000 the same cycle. Next cycle, lane0 = {1, 3, 64'hDEAD}, lane1 = {0, 0, 0}, `retiring_stations`=5'b01000, and `rr_ptr`=4.
- All valid from reset, held:
  - Stimulus: all five FUs hold `fu_valid`=1 from reset.
  - Required response: grant pairs are (0,1), (2,3), (4,0), (1,2) on consecutive cycles. Lane0/lane1 `rs_id` follow that order, one cycle delayed.
- Wrap-around:
  - Stimulus: `rr_ptr`=4, `fu_valid`=5'b10001.
  - Required response: lane0 `rs_id`=4, lane1 `rs_id`=0, and `rr_ptr`→1.
- Flush:
  - Stimulus: `flush`=1 with `fu_valid`=5'b11111.
  - Required response: `fu_ready`=0 that cycle; next cycle all lanes invalid and zero; `rr_ptr` unchanged. Stall FUs are granted after `flush` drops, with no result lost or duplicated.
- Randomised check:
  - Stimulus: random `fu_valid`/`fu_result` under the hold-until-ready protocol for 10k cycles.
  - Required response:
    - Every accepted result appears exactly once on the CDB with the correct `rs_id`.
    - No grant is issued without `fu_valid`.
    - The fairness bound is never exceeded.
